// File: rtl/mem_stage_waitstate.sv
// mem_stage_waitstate
// MEM stage of the ARM pipeline: word-addressed data memory behind a
// configurable wait-state access model. A load or store occupies the stage
// for WAIT_CYCLES+1 cycles, during which StallOut freezes every upstream
// stage. The MEM/WB pipeline register is built in. It takes a bubble while
// stalled and captures the instruction on the cycle its access completes.

module mem_stage_waitstate #(
  parameter int N           = 32,   // datapath width (data, address)
  parameter int DEPTH       = 64,   // memory size in N-bit words, power of 2
  parameter int BASE_ADDR   = 1024, // byte address of word 0
  parameter int WAIT_CYCLES = 3     // extra cycles per load/store, 0..15
) (
  input  logic         clk,
  input  logic         rst,            // asynchronous, active-low
  input  logic         WB_ENIn,
  input  logic         MEM_R_ENIn,
  input  logic         MEM_W_ENIn,
  input  logic [3:0]   DestIn,
  input  logic [N-1:0] ALU_ResIn,
  input  logic [N-1:0] Value_RmIn,
  output logic         StallOut,
  output logic         WB_ENOut,
  output logic         MEM_R_ENOut,
  output logic [3:0]   DestOut,
  output logic [N-1:0] ALU_ResOut,
  output logic [N-1:0] DataMemoryOut,
  output logic         AddrErrOut
);

  localparam int           ADDR_BITS = $clog2(DEPTH);
  localparam logic [N-1:0] BASE      = N'(BASE_ADDR);
  localparam logic [N-1:0] SPAN      = N'(DEPTH * 4);
  localparam bit           HAS_WAIT  = (WAIT_CYCLES > 0);
  // The first stall cycle is spent in IDLE, so BUSY counts one less.
  localparam logic [3:0]   CNT_INIT  = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [3:0]           cnt;
  logic [3:0]           cnt_next;

  logic                 req;
  logic [N-1:0]         off;
  logic [ADDR_BITS-1:0] idx;
  logic                 in_range;
  logic                 stall;
  logic                 complete;
  logic                 mem_we;
  logic [N-1:0]         rd_word;
  logic [N-1:0]         load_data;

  logic [N-1:0]         mem [DEPTH];

  // Address decode: byte address relative to the base, wrapping at N bits,
  // so addresses below the base land far out of range.
  always_comb begin
    req      = MEM_R_ENIn | MEM_W_ENIn;
    off      = ALU_ResIn - BASE;
    idx      = off[ADDR_BITS+1:2];
    in_range = (off < SPAN);
  end

  // Wait-state sequencer: next state, countdown and stall/complete strobes.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    complete   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (HAS_WAIT) begin
            stall      = 1'b1;
            cnt_next   = CNT_INIT;
            state_next = BUSY;
          end else begin
            complete   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          stall    = 1'b1;
          cnt_next = cnt - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign StallOut = stall;

  // Memory port controls: reads are combinational so that a combined
  // read/write returns the word as it was before this edge's store.
  always_comb begin
    mem_we    = complete & MEM_W_ENIn & in_range;
    rd_word   = mem[idx];
    load_data = (complete & MEM_R_ENIn & in_range) ? rd_word : '0;
  end

  // Sequencer state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Data memory write port.
  // NOTE: the array deliberately has no reset; clearing it would turn the
  // RAM into flops. Reset still aborts a pending store because it returns
  // the sequencer to IDLE before the completion edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= Value_RmIn;
    end
  end

  // MEM/WB pipeline register: capture on a non-stalled edge, otherwise
  // insert a bubble by clearing the control flags and holding the payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_ENOut      <= 1'b0;
      MEM_R_ENOut   <= 1'b0;
      DestOut       <= 4'd0;
      ALU_ResOut    <= '0;
      DataMemoryOut <= '0;
      AddrErrOut    <= 1'b0;
    end else if (!stall) begin
      WB_ENOut      <= WB_ENIn;
      MEM_R_ENOut   <= MEM_R_ENIn;
      DestOut       <= DestIn;
      ALU_ResOut    <= ALU_ResIn;
      DataMemoryOut <= load_data;
      AddrErrOut    <= complete & ~in_range;
    end else begin
      WB_ENOut      <= 1'b0;
      MEM_R_ENOut   <= 1'b0;
      AddrErrOut    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_waitstate.sv
// tb_mem_stage_waitstate
// Two instances (3 wait states and 0 wait states) share one clock and reset.
// A transaction-level model predicts stall and MEM/WB contents every cycle;
// directed sequences add hand-computed literal expectations.

module tb_mem_stage_waitstate;

  localparam int N     = 32;
  localparam int DEPTH = 64;
  localparam int BASE  = 1024;

  logic        clk = 1'b0;
  logic        rst;

  logic        wb_i   [2];
  logic        r_i    [2];
  logic        w_i    [2];
  logic [3:0]  dest_i [2];
  logic [31:0] alu_i  [2];
  logic [31:0] val_i  [2];

  logic        stall_o [2];
  logic        wb_o    [2];
  logic        r_o     [2];
  logic [3:0]  dest_o  [2];
  logic [31:0] alu_o   [2];
  logic [31:0] data_o  [2];
  logic        err_o   [2];

  int wait_of [2] = '{3, 0};

  always #5 clk = ~clk;

  mem_stage_waitstate #(.N(N), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_wait3 (
    .clk(clk), .rst(rst),
    .WB_ENIn(wb_i[0]), .MEM_R_ENIn(r_i[0]), .MEM_W_ENIn(w_i[0]), .DestIn(dest_i[0]),
    .ALU_ResIn(alu_i[0]), .Value_RmIn(val_i[0]),
    .StallOut(stall_o[0]), .WB_ENOut(wb_o[0]), .MEM_R_ENOut(r_o[0]), .DestOut(dest_o[0]),
    .ALU_ResOut(alu_o[0]), .DataMemoryOut(data_o[0]), .AddrErrOut(err_o[0])
  );

  mem_stage_waitstate #(.N(N), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_wait0 (
    .clk(clk), .rst(rst),
    .WB_ENIn(wb_i[1]), .MEM_R_ENIn(r_i[1]), .MEM_W_ENIn(w_i[1]), .DestIn(dest_i[1]),
    .ALU_ResIn(alu_i[1]), .Value_RmIn(val_i[1]),
    .StallOut(stall_o[1]), .WB_ENOut(wb_o[1]), .MEM_R_ENOut(r_o[1]), .DestOut(dest_o[1]),
    .ALU_ResOut(alu_o[1]), .DataMemoryOut(data_o[1]), .AddrErrOut(err_o[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s dut%0d: got %h expected %h", name, d, got, want);
  endtask

  // ---------------- behavioural model ----------------
  // age = cycles the current instruction has already spent in the stage.
  int          age      [2];
  int          stall_cnt[2];
  logic        exp_wb   [2];
  logic        exp_r    [2];
  logic [3:0]  exp_dest [2];
  logic [31:0] exp_alu  [2];
  logic [31:0] exp_data [2];
  logic        exp_err  [2];
  logic [31:0] mmem     [2][DEPTH];

  function automatic bit in_window(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= BASE) && (ua < BASE + 4 * DEPTH);
  endfunction

  // Compare every cycle at the falling edge, then advance the model to
  // what the next rising edge must produce.
  initial begin
    for (int d = 0; d < 2; d++) begin
      age[d] = 0; stall_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bit          req;
        bit          st;
        bit          inr;
        int          word;
        if (!rst) begin
          age[d] = 0;
          exp_wb[d] = 0; exp_r[d] = 0; exp_dest[d] = 0;
          exp_alu[d] = 0; exp_data[d] = 0; exp_err[d] = 0;
        end
        req = r_i[d] | w_i[d];
        st  = req && (age[d] < wait_of[d]);
        check("stall",    d, 32'(stall_o[d]), 32'(st));
        check("wb_en",    d, 32'(wb_o[d]),    32'(exp_wb[d]));
        check("mem_r_en", d, 32'(r_o[d]),     32'(exp_r[d]));
        check("dest",     d, 32'(dest_o[d]),  32'(exp_dest[d]));
        check("alu_res",  d, alu_o[d],        exp_alu[d]);
        check("mem_data", d, data_o[d],       exp_data[d]);
        check("addr_err", d, 32'(err_o[d]),   32'(exp_err[d]));
        if (stall_o[d] === 1'b1) stall_cnt[d]++;
        if (rst) begin
          if (st) begin
            age[d]++;
            exp_wb[d] = 0; exp_r[d] = 0; exp_err[d] = 0;
          end else begin
            age[d]      = 0;
            exp_wb[d]   = wb_i[d];
            exp_r[d]    = r_i[d];
            exp_dest[d] = dest_i[d];
            exp_alu[d]  = alu_i[d];
            exp_data[d] = 0;
            exp_err[d]  = 0;
            if (req) begin
              inr  = in_window(alu_i[d]);
              word = (int'(alu_i[d]) - BASE) / 4;
              exp_err[d] = !inr;
              if (inr && r_i[d]) exp_data[d] = mmem[d][word];
              if (inr && w_i[d]) mmem[d][word] = val_i[d];
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_idle(input int d);
    wb_i[d] = 0; r_i[d] = 0; w_i[d] = 0; dest_i[d] = 0; alu_i[d] = 0; val_i[d] = 0;
  endtask

  // Present one instruction and hold it for its full access time.
  // Returns 1 time unit after the edge on which it left the stage.
  task automatic issue(input int d, input logic wb, input logic r, input logic w,
                       input logic [3:0] dest, input logic [31:0] alu, input logic [31:0] val);
    wb_i[d] = wb; r_i[d] = r; w_i[d] = w; dest_i[d] = dest; alu_i[d] = alu; val_i[d] = val;
    stall_cnt[d] = 0;
    repeat ((r | w) ? wait_of[d] + 1 : 1) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input int d);
    set_idle(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_idle(0);
    set_idle(1);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // ALU op passes through in one cycle, no stall
    issue(0, 1, 0, 0, 4'd5, 32'd7, 0);
    check("alu_wb_lit",     0, 32'(wb_o[0]), 1);
    check("alu_dest_lit",   0, 32'(dest_o[0]), 5);
    check("alu_res_lit",    0, alu_o[0], 7);
    check("alu_stalls_lit", 0, stall_cnt[0], 0);

    // store then load at 1024
    issue(0, 0, 0, 1, 4'd0, 32'd1024, 32'hDEADBEEF);
    check("st_stalls_lit", 0, stall_cnt[0], 3);
    issue(0, 1, 1, 0, 4'd2, 32'd1024, 0);
    check("ld_data_lit",   0, data_o[0], 32'hDEADBEEF);
    check("ld_r_en_lit",   0, 32'(r_o[0]), 1);
    check("ld_stalls_lit", 0, stall_cnt[0], 3);

    issue(0, 0, 0, 1, 4'd0, 32'd1028, 32'h0000A5A5);
    issue(0, 0, 0, 1, 4'd0, 32'd1036, 32'h00000011);

    // byte offset within a word is ignored
    issue(0, 1, 1, 0, 4'd3, 32'd1027, 0);
    check("ld_byteoff_lit", 0, data_o[0], 32'hDEADBEEF);

    // out-of-range load, error for one cycle only
    issue(0, 1, 1, 0, 4'd4, 32'd1280, 0);
    check("oor_err_lit",  0, 32'(err_o[0]), 1);
    check("oor_data_lit", 0, data_o[0], 0);
    idle_cycle(0);
    check("oor_err_clr_lit", 0, 32'(err_o[0]), 0);

    // out-of-range store and an address below the base
    issue(0, 0, 0, 1, 4'd0, 32'd1280, 32'h12345678);
    check("oor_st_err_lit", 0, 32'(err_o[0]), 1);
    issue(0, 1, 1, 0, 4'd4, 32'd1020, 0);
    check("below_err_lit", 0, 32'(err_o[0]), 1);
    issue(0, 1, 1, 0, 4'd2, 32'd1024, 0);
    check("w0_kept_lit", 0, data_o[0], 32'hDEADBEEF);

    // combined read/write returns the old word
    issue(0, 1, 1, 1, 4'd6, 32'd1036, 32'h00000022);
    check("rw_old_lit", 0, data_o[0], 32'h00000011);
    issue(0, 1, 1, 0, 4'd6, 32'd1036, 0);
    check("rw_new_lit", 0, data_o[0], 32'h00000022);

    // reset during the second cycle of a store to 1028
    issue(0, 1, 0, 0, 4'd9, 32'h55, 0);
    wb_i[0] = 0; r_i[0] = 0; w_i[0] = 1; dest_i[0] = 4'd1;
    alu_i[0] = 32'd1028; val_i[0] = 32'hBAD0BAD0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_dest_lit", 0, 32'(dest_o[0]), 0);
    check("rst_alu_lit",  0, alu_o[0], 0);
    @(posedge clk);
    #1 set_idle(0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_stall_lit", 0, 32'(stall_o[0]), 0);
    issue(0, 1, 1, 0, 4'd7, 32'd1028, 0);
    check("rst_mem_kept_lit", 0, data_o[0], 32'h0000A5A5);

    // back-to-back load then ALU op
    issue(0, 1, 1, 0, 4'd8, 32'd1024, 0);
    issue(0, 1, 0, 0, 4'd10, 32'h99, 0);
    check("b2b_dest_lit", 0, 32'(dest_o[0]), 10);
    check("b2b_alu_lit",  0, alu_o[0], 32'h99);
    set_idle(0);

    // zero-wait instance: back-to-back store/load at 1032
    issue(1, 0, 0, 1, 4'd0, 32'd1032, 32'hCAFEF00D);
    check("w0_st_stalls_lit", 1, stall_cnt[1], 0);
    issue(1, 1, 1, 0, 4'd11, 32'd1032, 0);
    check("w0_ld_data_lit",   1, data_o[1], 32'hCAFEF00D);
    check("w0_ld_r_en_lit",   1, 32'(r_o[1]), 1);
    check("w0_ld_stalls_lit", 1, stall_cnt[1], 0);
    issue(1, 1, 0, 0, 4'd5, 32'd7, 0);
    check("w0_alu_res_lit", 1, alu_o[1], 7);
    set_idle(1);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
